// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone command master: FSM states,
// response status codes and the fixed classic-cycle tag values.
package wb_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      GAP  = 2'd2,
      RESP = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_ERR     = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_RETRY   = 2'b11
   } status_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone bus signals of the command master.
interface wb_cmd_master_if #(
   parameter int dw = 32,
   parameter int aw = 32
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [aw-1:0] cmd_adr;
   logic [dw-1:0] cmd_dat;
   logic [3:0]    cmd_sel;
   logic          cmd_we;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [dw-1:0] rsp_dat;
   logic [1:0]    rsp_status;
   logic [aw-1:0] wb_adr_o;
   logic [dw-1:0] wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic [dw-1:0] wb_dat_i;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic          wb_rty_i;
   logic          busy;

   modport master (
      input  cmd_valid, cmd_adr, cmd_dat, cmd_sel, cmd_we, rsp_ready,
             wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
      output cmd_ready, rsp_valid, rsp_dat, rsp_status,
             wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
             wb_cti_o, wb_bte_o, busy
   );

   modport slave (
      output cmd_valid, cmd_adr, cmd_dat, cmd_sel, cmd_we, rsp_ready,
             wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
      input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
             wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
             wb_cti_o, wb_bte_o, busy
   );
endinterface

// File: rtl/wb_master_timer.sv
// Per-attempt cycle counter; tc flags the last cycle allowed before a timeout.
module wb_master_timer #(
   parameter int TIMEOUT = 255,
   localparam int TW     = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   logic [TW-1:0] count_r;

   // counter: clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (inc) begin
         count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign tc = (count_r == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Single-transfer Wishbone classic master: one command in, one bus cycle out,
// with err/ack/rty handling, bounded retries, timeout and a registered response.
module wb_cmd_master
   import wb_master_pkg::*;
#(
   parameter int dw        = 32,
   parameter int aw        = 32,
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3
) (
   input logic             wb_clk,
   input logic             wb_rst_n,
   wb_cmd_master_if.master bus
);
   localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

   state_t        state_r, state_nxt_s;
   status_t       status_r, status_nxt_s;
   logic [aw-1:0] adr_r;
   logic [dw-1:0] dat_r, rsp_dat_r, rsp_dat_nxt_s;
   logic [3:0]    sel_r, retry_cnt_r, retry_nxt_s;
   logic          we_r, cyc_r, cyc_nxt_s, rsp_valid_r, rsp_valid_nxt_s;
   logic          latch_s, tmr_clr_s, tmr_inc_s, tmr_tc_s;

   wb_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (wb_clk),
      .rst_n (wb_rst_n),
      .clr   (tmr_clr_s),
      .inc   (tmr_inc_s),
      .tc    (tmr_tc_s)
   );

   // state register
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) state_r <= IDLE;
      else           state_r <= state_nxt_s;
   end

   // next-state decode; termination priority is err > ack > rty > timeout
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (bus.cmd_valid) state_nxt_s = BUS; else state_nxt_s = IDLE;
         BUS: begin
            if (bus.wb_err_i || bus.wb_ack_i) state_nxt_s = RESP;
            else if (bus.wb_rty_i)            state_nxt_s = (retry_cnt_r < RETRY_LIM) ? GAP : RESP;
            else if (tmr_tc_s)                state_nxt_s = RESP;
            else                              state_nxt_s = BUS;
         end
         GAP:     state_nxt_s = BUS;
         RESP:    if (bus.rsp_ready) state_nxt_s = IDLE; else state_nxt_s = RESP;
         default: state_nxt_s = IDLE;
      endcase
   end

   // next values of the registered outputs and counter controls
   always_comb begin
      cyc_nxt_s       = 1'b0;
      rsp_valid_nxt_s = 1'b0;
      rsp_dat_nxt_s   = rsp_dat_r;
      status_nxt_s    = status_r;
      retry_nxt_s     = retry_cnt_r;
      latch_s         = 1'b0;
      tmr_clr_s       = 1'b0;
      tmr_inc_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.cmd_valid) begin
               latch_s     = 1'b1;
               cyc_nxt_s   = 1'b1;
               retry_nxt_s = 4'd0;
               tmr_clr_s   = 1'b1;
            end else begin
               latch_s     = 1'b0;
            end
         end
         BUS: begin
            if (bus.wb_err_i) begin
               status_nxt_s    = ST_ERR;
               rsp_dat_nxt_s   = '0;
               rsp_valid_nxt_s = 1'b1;
            end else if (bus.wb_ack_i) begin
               status_nxt_s    = ST_OK;
               rsp_dat_nxt_s   = we_r ? '0 : bus.wb_dat_i;
               rsp_valid_nxt_s = 1'b1;
            end else if (bus.wb_rty_i) begin
               if (retry_cnt_r < RETRY_LIM) begin
                  retry_nxt_s     = retry_cnt_r + 4'd1;
               end else begin
                  status_nxt_s    = ST_RETRY;
                  rsp_dat_nxt_s   = '0;
                  rsp_valid_nxt_s = 1'b1;
               end
            end else if (tmr_tc_s) begin
               status_nxt_s    = ST_TIMEOUT;
               rsp_dat_nxt_s   = '0;
               rsp_valid_nxt_s = 1'b1;
            end else begin
               cyc_nxt_s = 1'b1;
               tmr_inc_s = 1'b1;
            end
         end
         GAP: begin
            cyc_nxt_s = 1'b1;
            tmr_clr_s = 1'b1;
         end
         RESP: begin
            if (bus.rsp_ready) rsp_valid_nxt_s = 1'b0;
            else               rsp_valid_nxt_s = 1'b1;
         end
         default: cyc_nxt_s = 1'b0;
      endcase
   end

   // command latch, bus strobe and response registers
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         adr_r       <= '0;
         dat_r       <= '0;
         sel_r       <= 4'd0;
         we_r        <= 1'b0;
         cyc_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_dat_r   <= '0;
         status_r    <= ST_OK;
         retry_cnt_r <= 4'd0;
      end else begin
         if (latch_s) begin
            adr_r <= bus.cmd_adr;
            dat_r <= bus.cmd_dat;
            sel_r <= bus.cmd_sel;
            we_r  <= bus.cmd_we;
         end else begin
            adr_r <= adr_r;
            dat_r <= dat_r;
            sel_r <= sel_r;
            we_r  <= we_r;
         end
         cyc_r       <= cyc_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_dat_r   <= rsp_dat_nxt_s;
         status_r    <= status_nxt_s;
         retry_cnt_r <= retry_nxt_s;
      end
   end

   // cmd_ready is forced low while reset is held even though state is IDLE
   assign bus.cmd_ready  = (state_r == IDLE) && wb_rst_n;
   assign bus.busy       = (state_r != IDLE);
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_dat    = rsp_dat_r;
   assign bus.rsp_status = status_r;
   assign bus.wb_adr_o   = adr_r;
   assign bus.wb_dat_o   = dat_r;
   assign bus.wb_sel_o   = sel_r;
   assign bus.wb_we_o    = we_r;
   assign bus.wb_cyc_o   = cyc_r;
   assign bus.wb_stb_o   = cyc_r;
   assign bus.wb_cti_o   = CTI_CLASSIC;
   assign bus.wb_bte_o   = BTE_LINEAR;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised bench for wb_cmd_master: scripted registered slave plus an
// attempt-level model that predicts status, data, latency and gap count.
module tb_wb_cmd_master;
   localparam int TO   = 16;
   localparam int MAXR = 3;
   localparam int T_ACK = 0, T_ERR = 1, T_RTY = 2, T_NONE = 3, T_BOTH = 4;

   logic wb_clk = 1'b0;
   logic wb_rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   int          term_q [6];
   int          lat_q  [6];
   bit          stale_en = 1'b0;
   logic [31:0] rd_data = 32'd0;
   int          s_cnt, s_att;
   bit          s_stale_done;

   wb_cmd_master_if #(.dw(32), .aw(32)) bus ();

   wb_cmd_master #(.dw(32), .aw(32), .TIMEOUT(TO), .MAX_RETRY(MAXR)) dut (
      .wb_clk   (wb_clk),
      .wb_rst_n (wb_rst_n),
      .bus      (bus.master)
   );

   always #5 wb_clk = ~wb_clk;

   assign bus.wb_dat_i = bus.wb_ack_i ? rd_data : ~rd_data;

   // scripted slave: per attempt, wait lat cycles of stb, then terminate for one cycle
   always @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         bus.wb_ack_i <= 1'b0; bus.wb_err_i <= 1'b0; bus.wb_rty_i <= 1'b0;
         s_cnt <= 0; s_att <= 0; s_stale_done <= 1'b0;
      end else if (bus.cmd_valid && bus.cmd_ready) begin
         bus.wb_ack_i <= 1'b0; bus.wb_err_i <= 1'b0; bus.wb_rty_i <= 1'b0;
         s_cnt <= 0; s_att <= 0; s_stale_done <= 1'b0;
      end else if (bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i) begin
         bus.wb_ack_i <= 1'b0; bus.wb_err_i <= 1'b0; bus.wb_rty_i <= 1'b0;
         if (bus.wb_ack_i && !bus.wb_err_i && stale_en && !s_stale_done) begin
            bus.wb_ack_i <= 1'b1;
            s_stale_done <= 1'b1;
         end
      end else if (bus.wb_cyc_o && bus.wb_stb_o && s_att < 6 && term_q[s_att] != T_NONE) begin
         if (s_cnt == lat_q[s_att]) begin
            bus.wb_ack_i <= (term_q[s_att] == T_ACK) || (term_q[s_att] == T_BOTH);
            bus.wb_err_i <= (term_q[s_att] == T_ERR) || (term_q[s_att] == T_BOTH);
            bus.wb_rty_i <= (term_q[s_att] == T_RTY);
            s_cnt <= 0;
            s_att <= s_att + 1;
         end else begin
            s_cnt <= s_cnt + 1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // attempt-by-attempt outcome of the scripted slave
   function automatic void model(input bit we, input logic [31:0] rd,
                                 output int lat, output int gaps,
                                 output logic [1:0] st, output logic [31:0] dat);
      int r;
      r = 0; lat = 0; gaps = 0; st = 2'b00; dat = 32'd0;
      for (int a = 0; a < 6; a++) begin
         if (term_q[a] == T_NONE || lat_q[a] + 2 > TO) begin
            lat += TO; st = 2'b10; return;
         end
         lat += lat_q[a] + 2;
         if (term_q[a] == T_ERR || term_q[a] == T_BOTH) begin st = 2'b01; return; end
         if (term_q[a] == T_ACK) begin st = 2'b00; dat = we ? 32'd0 : rd; return; end
         if (r < MAXR) begin r++; gaps++; lat++; end
         else begin st = 2'b11; return; end
      end
   endfunction

   task automatic set_script(input int t0, input int t1, input int t2, input int t3, input int t4);
      term_q[0] = t0; term_q[1] = t1; term_q[2] = t2; term_q[3] = t3; term_q[4] = t4; term_q[5] = T_ACK;
      for (int a = 0; a < 6; a++) lat_q[a] = 0;
   endtask

   task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int hold);
      int          e_lat, e_gaps, n, gaps;
      logic [1:0]  e_st;
      logic [31:0] e_dat;
      bit          done;
      model(we, rd_data, e_lat, e_gaps, e_st, e_dat);
      bus.cmd_adr = adr; bus.cmd_dat = dat; bus.cmd_sel = sel; bus.cmd_we = we;
      bus.cmd_valid = 1'b1;
      check_eq("ready_idle", bus.cmd_ready, 1'b1);
      @(posedge wb_clk); #1;
      bus.cmd_valid = 1'b0;
      check_eq("accept", {bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready, bus.busy}, 4'b1101);
      n = 0; gaps = 0; done = 1'b0;
      while (!done && n < 200) begin
         if (bus.wb_stb_o)
            check_eq("bus_fields", {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o},
                     {adr, dat, sel, we, 1'b1});
         else
            gaps++;
         @(posedge wb_clk); #1;
         n++;
         if (bus.rsp_valid) done = 1'b1;
      end
      check_eq("rsp_wait", done, 1'b1);
      check_eq("latency", n, e_lat);
      check_eq("gaps", gaps, e_gaps);
      check_eq("rsp", {bus.rsp_status, bus.rsp_dat, bus.wb_cyc_o}, {e_st, e_dat, 1'b0});
      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = 1'b0;
         if (h > 0) begin
            bus.cmd_valid = 1'b1; bus.cmd_adr = $urandom; bus.cmd_we = 1'b1;
         end
         @(posedge wb_clk); #1;
         check_eq("hold", {bus.rsp_valid, bus.rsp_status, bus.rsp_dat, bus.wb_cyc_o, bus.cmd_ready},
                  {1'b1, e_st, e_dat, 1'b0, 1'b0});
      end
      bus.rsp_ready = 1'b1;
      @(posedge wb_clk); #1;
      bus.rsp_ready = 1'b0;
      check_eq("handshake", {bus.rsp_valid, bus.wb_cyc_o, bus.cmd_ready, bus.busy}, 4'b0010);
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int r;
      bus.cmd_valid = 1'b0; bus.cmd_adr = 32'd0; bus.cmd_dat = 32'd0;
      bus.cmd_sel = 4'd0; bus.cmd_we = 1'b0; bus.rsp_ready = 1'b0;
      set_script(T_ACK, T_ACK, T_ACK, T_ACK, T_ACK);
      repeat (3) @(posedge wb_clk);
      #1;
      check_eq("in_reset", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                            bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.rsp_dat, bus.rsp_status}, 0);
      @(negedge wb_clk); wb_rst_n = 1'b1;
      @(posedge wb_clk); #1;
      check_eq("post_reset", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.wb_cti_o, bus.wb_bte_o}, 8'b1000_0000);

      rd_data = 32'h1357_9BDF;
      do_txn(1'b1, 32'h9000_0004, 32'hDEAD_BEEF, 4'hF, 0);
      stale_en = 1'b1; rd_data = 32'h1234_5678;
      do_txn(1'b0, 32'h9000_0008, 32'hA5A5_0000, 4'hF, 2);
      stale_en = 1'b0;
      set_script(T_RTY, T_RTY, T_ACK, T_ACK, T_ACK);
      do_txn(1'b0, 32'h9000_0010, 32'h0, 4'h3, 0);
      set_script(T_RTY, T_RTY, T_RTY, T_RTY, T_ACK);
      do_txn(1'b0, 32'h9000_0014, 32'h0, 4'hF, 1);
      set_script(T_NONE, T_ACK, T_ACK, T_ACK, T_ACK);
      do_txn(1'b1, 32'h9000_0018, 32'hCAFE_F00D, 4'hC, 0);
      set_script(T_BOTH, T_ACK, T_ACK, T_ACK, T_ACK);
      do_txn(1'b0, 32'h9000_001C, 32'h0, 4'hF, 0);
      set_script(T_ACK, T_ACK, T_ACK, T_ACK, T_ACK);
      do_txn(1'b0, 32'h9000_0020, 32'h0, 4'h1, 5);

      // reset in the middle of a bus cycle that never terminates
      set_script(T_NONE, T_ACK, T_ACK, T_ACK, T_ACK);
      bus.cmd_adr = 32'h9000_0024; bus.cmd_we = 1'b1; bus.cmd_valid = 1'b1;
      @(posedge wb_clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (3) @(posedge wb_clk);
      #3 wb_rst_n = 1'b0;
      #1 check_eq("async_drop", {bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready, bus.busy, bus.rsp_valid}, 5'b0);
      @(negedge wb_clk); wb_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge wb_clk); #1;
         check_eq("after_rst", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.wb_cyc_o}, 4'b1000);
      end

      for (int t = 0; t < 40; t++) begin
         for (int a = 0; a < 6; a++) begin
            r = $urandom_range(0, 9);
            term_q[a] = (r < 4) ? T_ACK : (r < 5) ? T_ERR : (r < 8) ? T_RTY : (r < 9) ? T_NONE : T_BOTH;
            lat_q[a]  = ($urandom_range(0, 7) == 0) ? 14 + $urandom_range(0, 1) : $urandom_range(0, 3);
         end
         stale_en = $urandom_range(0, 1);
         rd_data  = $urandom;
         do_txn($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
